// File: rtl/pipe_hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package pipe_hazard_unit_pkg;

  typedef logic [1:0] fwd_sel_t;
  typedef logic [1:0] hz_state_t;

  // EXE operand forwarding selects
  localparam fwd_sel_t FWD_NONE = 2'd0;
  localparam fwd_sel_t FWD_MEM  = 2'd1;
  localparam fwd_sel_t FWD_WB   = 2'd2;

  // ID operand forwarding selects
  localparam logic ID_NOFWD  = 1'b0;
  localparam logic WB2ID_FWD = 1'b1;

  localparam hz_state_t ST_RUN      = 2'd0;
  localparam hz_state_t ST_LU_STALL = 2'd1;
  localparam hz_state_t ST_MEM_WAIT = 2'd2;

  localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle; master = pipeline, slave = hazard unit.
interface pipe_hazard_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] rs_id;
  logic [REG_AW-1:0] rt_id;
  logic              use_rt_id;
  logic [REG_AW-1:0] rs_exe;
  logic [REG_AW-1:0] rt_exe;
  logic [REG_AW-1:0] num_write_exe;
  logic [REG_AW-1:0] num_write_mem;
  logic [REG_AW-1:0] num_write_wb;
  logic              reg_write_exe;
  logic              reg_write_mem;
  logic              reg_write_wb;
  logic              is_load_exe;
  logic              is_load_mem;
  logic              redirect_exe;
  logic              mem_req_mem;
  logic              mem_ready;

  logic [1:0]        s_a_fwd_exe;
  logic [1:0]        s_b_fwd_exe;
  logic              s_a_fwd_id;
  logic              s_b_fwd_id;
  logic              nwrite_pc;
  logic              nwrite_if_id;
  logic              flush_if_id;
  logic              flush_id_exe;
  logic              hold_exe_mem;
  logic              hold_mem_wb;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output rs_id, rt_id, use_rt_id, rs_exe, rt_exe,
    output num_write_exe, num_write_mem, num_write_wb,
    output reg_write_exe, reg_write_mem, reg_write_wb,
    output is_load_exe, is_load_mem, redirect_exe, mem_req_mem, mem_ready,
    input  s_a_fwd_exe, s_b_fwd_exe, s_a_fwd_id, s_b_fwd_id,
    input  nwrite_pc, nwrite_if_id, flush_if_id, flush_id_exe,
    input  hold_exe_mem, hold_mem_wb, mem_timeout, stall_cycles
  );

  modport slave (
    input  rs_id, rt_id, use_rt_id, rs_exe, rt_exe,
    input  num_write_exe, num_write_mem, num_write_wb,
    input  reg_write_exe, reg_write_mem, reg_write_wb,
    input  is_load_exe, is_load_mem, redirect_exe, mem_req_mem, mem_ready,
    output s_a_fwd_exe, s_b_fwd_exe, s_a_fwd_id, s_b_fwd_id,
    output nwrite_pc, nwrite_if_id, flush_if_id, flush_id_exe,
    output hold_exe_mem, hold_mem_wb, mem_timeout, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_unit_fwd_select.sv
// Per-operand forwarding priority selector: MEM producer first, then WB.
module pipe_hazard_unit_fwd_select
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  logic              i_mem_ok,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic              i_wb_ok,
  input  logic [REG_AW-1:0] i_wb_dst,
  input  logic              i_block,
  output fwd_sel_t          o_sel_c
);

  always_comb begin
    o_sel_c = FWD_NONE;
    if (i_use && !i_block) begin
      if (i_mem_ok && (i_mem_dst == i_src)) begin
        o_sel_c = FWD_MEM;
      end else if (i_wb_ok && (i_wb_dst == i_src)) begin
        o_sel_c = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: operand forwarding,
// load-use bubbles, redirect flushes, data-memory freeze and stall accounting.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned MAX_WAIT   = 255,
  parameter int unsigned WAIT_W     = 8,
  parameter int unsigned CNT_W      = 32
) (
  input logic              clock,
  input logic              reset,
  pipe_hazard_unit_if.slave hz
);

  localparam int unsigned     BCNT_W      = 3;
  localparam logic [BCNT_W-1:0] BCNT_RELOAD = BCNT_W'(LU_BUBBLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(MAX_WAIT);

  hz_state_t          r_state;
  hz_state_t          w_state_nxt;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [BCNT_W-1:0]  w_bcnt_nxt;
  logic [WAIT_W-1:0]  r_wcnt;
  logic [WAIT_W-1:0]  w_wcnt_nxt;
  logic               r_timeout;
  logic               w_timeout_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic     w_mem_ok, w_wb_ok, w_exe_ok;
  logic     w_freeze, w_lu_hazard, w_in_lu;
  fwd_sel_t w_sel_a_exe, w_sel_b_exe, w_sel_a_id, w_sel_b_id;
  logic     w_nwrite_pc, w_nwrite_if_id, w_flush_if_id, w_flush_id_exe;
  logic     w_hold_exe_mem, w_hold_mem_wb;

  // A load in MEM has no data yet, so it is not a MEM-forwarding source
  assign w_mem_ok = hz.reg_write_mem && (|hz.num_write_mem) && !hz.is_load_mem;
  assign w_wb_ok  = hz.reg_write_wb  && (|hz.num_write_wb);
  assign w_exe_ok = hz.reg_write_exe && (|hz.num_write_exe);

  pipe_hazard_unit_fwd_select #(.REG_AW(REG_AW)) u_fwd_a_exe (
    .i_src(hz.rs_exe), .i_use(1'b1), .i_mem_ok(w_mem_ok), .i_mem_dst(hz.num_write_mem),
    .i_wb_ok(w_wb_ok), .i_wb_dst(hz.num_write_wb), .i_block(1'b0), .o_sel_c(w_sel_a_exe)
  );

  pipe_hazard_unit_fwd_select #(.REG_AW(REG_AW)) u_fwd_b_exe (
    .i_src(hz.rt_exe), .i_use(1'b1), .i_mem_ok(w_mem_ok), .i_mem_dst(hz.num_write_mem),
    .i_wb_ok(w_wb_ok), .i_wb_dst(hz.num_write_wb), .i_block(1'b0), .o_sel_c(w_sel_b_exe)
  );

  // ID only sees WB; suppressed when the same operand slot in EXE already forwards that register
  pipe_hazard_unit_fwd_select #(.REG_AW(REG_AW)) u_fwd_a_id (
    .i_src(hz.rs_id), .i_use(1'b1), .i_mem_ok(1'b0), .i_mem_dst('0),
    .i_wb_ok(w_wb_ok), .i_wb_dst(hz.num_write_wb),
    .i_block((w_sel_a_exe != FWD_NONE) && (hz.rs_exe == hz.rs_id)), .o_sel_c(w_sel_a_id)
  );

  pipe_hazard_unit_fwd_select #(.REG_AW(REG_AW)) u_fwd_b_id (
    .i_src(hz.rt_id), .i_use(hz.use_rt_id), .i_mem_ok(1'b0), .i_mem_dst('0),
    .i_wb_ok(w_wb_ok), .i_wb_dst(hz.num_write_wb),
    .i_block((w_sel_b_exe != FWD_NONE) && (hz.rt_exe == hz.rt_id)), .o_sel_c(w_sel_b_id)
  );

  assign w_freeze    = hz.mem_req_mem && !hz.mem_ready;
  assign w_lu_hazard = hz.is_load_exe && w_exe_ok &&
                       ((hz.num_write_exe == hz.rs_id) ||
                        (hz.use_rt_id && (hz.num_write_exe == hz.rt_id)));
  // Bubbles still owed, whether stalling now or parked in MEM_WAIT
  assign w_in_lu     = (r_state == ST_LU_STALL) ||
                       ((r_state == ST_MEM_WAIT) && (r_bcnt != '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_timeout <= w_timeout_nxt;
      if (w_nwrite_pc && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Next state and control outputs; priority freeze > redirect > load-use
  always_comb begin
    w_state_nxt    = r_state;
    w_bcnt_nxt     = r_bcnt;
    w_wcnt_nxt     = '0;
    w_timeout_nxt  = r_timeout;
    w_nwrite_pc    = 1'b0;
    w_nwrite_if_id = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_exe = 1'b0;
    w_hold_exe_mem = 1'b0;
    w_hold_mem_wb  = 1'b0;

    if (reset) begin
      w_flush_if_id  = 1'b1;
      w_flush_id_exe = 1'b1;
    end else if (w_freeze) begin
      w_nwrite_pc    = 1'b1;
      w_nwrite_if_id = 1'b1;
      w_hold_exe_mem = 1'b1;
      w_hold_mem_wb  = 1'b1;
      w_state_nxt    = ST_MEM_WAIT;
      w_wcnt_nxt     = (&r_wcnt) ? r_wcnt : r_wcnt + WAIT_W'(1);
      if (w_wcnt_nxt >= WAIT_LIMIT) begin
        w_timeout_nxt = 1'b1;
      end
    end else if (hz.redirect_exe) begin
      w_flush_if_id  = 1'b1;
      w_flush_id_exe = 1'b1;
      w_state_nxt    = ST_RUN;
      w_bcnt_nxt     = '0;
    end else if (w_in_lu) begin
      w_nwrite_pc    = 1'b1;
      w_nwrite_if_id = 1'b1;
      w_flush_id_exe = 1'b1;
      w_bcnt_nxt     = r_bcnt - BCNT_W'(1);
      w_state_nxt    = (r_bcnt == BCNT_W'(1)) ? ST_RUN : ST_LU_STALL;
    end else begin
      w_state_nxt = ST_RUN;
      if (w_lu_hazard) begin
        w_nwrite_pc    = 1'b1;
        w_nwrite_if_id = 1'b1;
        w_flush_id_exe = 1'b1;
        if (LU_BUBBLES > 1) begin
          w_state_nxt = ST_LU_STALL;
          w_bcnt_nxt  = BCNT_RELOAD;
        end
      end
    end
  end

  assign hz.s_a_fwd_exe  = w_sel_a_exe;
  assign hz.s_b_fwd_exe  = w_sel_b_exe;
  assign hz.s_a_fwd_id   = (w_sel_a_id == FWD_WB) ? WB2ID_FWD : ID_NOFWD;
  assign hz.s_b_fwd_id   = (w_sel_b_id == FWD_WB) ? WB2ID_FWD : ID_NOFWD;
  assign hz.nwrite_pc    = w_nwrite_pc;
  assign hz.nwrite_if_id = w_nwrite_if_id;
  assign hz.flush_if_id  = w_flush_if_id;
  assign hz.flush_id_exe = w_flush_id_exe;
  assign hz.hold_exe_mem = w_hold_exe_mem;
  assign hz.hold_mem_wb  = w_hold_mem_wb;
  assign hz.mem_timeout  = r_timeout;
  assign hz.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomized + directed bench for pipe_hazard_unit against a behavioural model.
module tb_pipe_hazard_unit;
  import pipe_hazard_unit_pkg::*;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned LU_BUBBLES = 2;
  localparam int unsigned MAX_WAIT   = 2;
  localparam int unsigned WAIT_W     = 3;
  localparam int unsigned CNT_W      = 4;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [1:0] fa_exe;
    logic [1:0] fb_exe;
    logic       fa_id;
    logic       fb_id;
  } fwd_t;

  typedef struct packed {
    logic nwrite_pc;
    logic nwrite_if_id;
    logic flush_if_id;
    logic flush_id_exe;
    logic hold_exe_mem;
    logic hold_mem_wb;
  } ctl_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: bubbles still owed, consecutive frozen cycles, sticky timeout, stall count
  int m_owed   = 0;
  int m_frozen = 0;
  int m_stalls = 0;
  bit m_timeout = 1'b0;

  always #5 clock = ~clock;

  pipe_hazard_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  pipe_hazard_unit #(
    .REG_AW(REG_AW), .LU_BUBBLES(LU_BUBBLES), .MAX_WAIT(MAX_WAIT),
    .WAIT_W(WAIT_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hz(hz)
  );

  task automatic litv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic lit1(input string name, input logic act, input logic exp);
    litv(name, 32'(act), 32'(exp));
  endtask

  function automatic bit produces(input logic rw, input logic [REG_AW-1:0] n);
    return rw && (n != 0);
  endfunction

  function automatic logic [1:0] exe_sel(input logic [REG_AW-1:0] r);
    if (produces(hz.reg_write_mem, hz.num_write_mem) && !hz.is_load_mem && hz.num_write_mem == r)
      return FWD_MEM;
    if (produces(hz.reg_write_wb, hz.num_write_wb) && hz.num_write_wb == r)
      return FWD_WB;
    return FWD_NONE;
  endfunction

  function automatic fwd_t exp_fwd();
    fwd_t f;
    bit wb;
    wb = produces(hz.reg_write_wb, hz.num_write_wb);
    f.fa_exe = exe_sel(hz.rs_exe);
    f.fb_exe = exe_sel(hz.rt_exe);
    f.fa_id  = wb && hz.num_write_wb == hz.rs_id &&
               !(f.fa_exe != FWD_NONE && hz.rs_exe == hz.rs_id);
    f.fb_id  = hz.use_rt_id && wb && hz.num_write_wb == hz.rt_id &&
               !(f.fb_exe != FWD_NONE && hz.rt_exe == hz.rt_id);
    return f;
  endfunction

  function automatic bit freeze_now();
    return hz.mem_req_mem && !hz.mem_ready;
  endfunction

  function automatic bit hazard_now();
    return hz.is_load_exe && produces(hz.reg_write_exe, hz.num_write_exe) &&
           (hz.num_write_exe == hz.rs_id || (hz.use_rt_id && hz.num_write_exe == hz.rt_id));
  endfunction

  function automatic ctl_t exp_ctl();
    ctl_t c;
    c = '0;
    if (reset) begin
      c.flush_if_id = 1'b1; c.flush_id_exe = 1'b1;
    end else if (freeze_now()) begin
      c.nwrite_pc = 1'b1; c.nwrite_if_id = 1'b1; c.hold_exe_mem = 1'b1; c.hold_mem_wb = 1'b1;
    end else if (hz.redirect_exe) begin
      c.flush_if_id = 1'b1; c.flush_id_exe = 1'b1;
    end else if (m_owed > 0 || hazard_now()) begin
      c.nwrite_pc = 1'b1; c.nwrite_if_id = 1'b1; c.flush_id_exe = 1'b1;
    end
    return c;
  endfunction

  function automatic bit stall_exp();
    ctl_t c;
    c = exp_ctl();
    return c.nwrite_pc;
  endfunction

  // Model advance at each active edge (inputs change only #1 later)
  always @(posedge clock) begin
    if (reset) begin
      m_owed <= 0; m_frozen <= 0; m_stalls <= 0; m_timeout <= 1'b0;
    end else begin
      if (stall_exp() && m_stalls < CNT_MAX) m_stalls <= m_stalls + 1;
      if (freeze_now()) begin
        m_frozen <= m_frozen + 1;
        if (m_frozen + 1 >= int'(MAX_WAIT)) m_timeout <= 1'b1;
      end else begin
        m_frozen <= 0;
        if (hz.redirect_exe)  m_owed <= 0;
        else if (m_owed > 0)  m_owed <= m_owed - 1;
        else if (hazard_now()) m_owed <= int'(LU_BUBBLES) - 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      fwd_t af;
      ctl_t ac;
      af = {hz.s_a_fwd_exe, hz.s_b_fwd_exe, hz.s_a_fwd_id, hz.s_b_fwd_id};
      ac = {hz.nwrite_pc, hz.nwrite_if_id, hz.flush_if_id, hz.flush_id_exe,
            hz.hold_exe_mem, hz.hold_mem_wb};
      litv("model_fwd", 32'(af), 32'(exp_fwd()));
      litv("model_ctl", 32'(ac), 32'(exp_ctl()));
      lit1("model_mem_timeout", hz.mem_timeout, m_timeout);
      litv("model_stall_cycles", 32'(hz.stall_cycles), 32'(m_stalls));
    end
  end

  task automatic idle();
    hz.rs_id = '0; hz.rt_id = '0; hz.use_rt_id = 1'b0; hz.rs_exe = '0; hz.rt_exe = '0;
    hz.num_write_exe = '0; hz.num_write_mem = '0; hz.num_write_wb = '0;
    hz.reg_write_exe = 1'b0; hz.reg_write_mem = 1'b0; hz.reg_write_wb = 1'b0;
    hz.is_load_exe = 1'b0; hz.is_load_mem = 1'b0; hz.redirect_exe = 1'b0;
    hz.mem_req_mem = 1'b0; hz.mem_ready = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clock); #1;
  endtask

  task automatic settle();
    @(negedge clock); #1;
  endtask

  task automatic load_use_r5();
    idle();
    hz.is_load_exe = 1'b1; hz.reg_write_exe = 1'b1; hz.num_write_exe = 5; hz.rs_id = 5;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    nxt(); chk_en = 1'b1;
    settle();
    lit1("rst_flush_if_id", hz.flush_if_id, 1'b1);
    lit1("rst_flush_id_exe", hz.flush_id_exe, 1'b1);
    lit1("rst_nwrite_pc", hz.nwrite_pc, 1'b0);
    litv("rst_stall_cycles", 32'(hz.stall_cycles), 32'd0);
    lit1("rst_mem_timeout", hz.mem_timeout, 1'b0);

    // EXE forwarding priorities and the producer qualification rule
    nxt(); reset = 1'b0;
    hz.reg_write_mem = 1'b1; hz.num_write_mem = 3; hz.rs_exe = 3;
    settle();
    litv("alu_pair_fwd_a_mem", 32'(hz.s_a_fwd_exe), 32'd1);
    lit1("alu_pair_no_stall", hz.nwrite_pc, 1'b0);
    nxt(); hz.reg_write_wb = 1'b1; hz.num_write_wb = 3; hz.rt_exe = 3;
    settle();
    litv("mem_beats_wb_b", 32'(hz.s_b_fwd_exe), 32'd1);
    nxt(); hz.is_load_mem = 1'b1;
    settle();
    litv("load_in_mem_falls_to_wb", 32'(hz.s_a_fwd_exe), 32'd2);
    nxt(); idle(); hz.reg_write_mem = 1'b1; hz.num_write_mem = 0; hz.rs_exe = 0;
    settle();
    litv("r0_never_forwarded", 32'(hz.s_a_fwd_exe), 32'd0);
    nxt(); idle(); hz.num_write_mem = 7; hz.rs_exe = 7;
    settle();
    litv("no_reg_write_no_fwd", 32'(hz.s_a_fwd_exe), 32'd0);

    // WB->ID forwarding, rt-as-immediate, and EXE-slot suppression
    nxt(); idle(); hz.reg_write_wb = 1'b1; hz.num_write_wb = 9; hz.rs_id = 9; hz.rt_id = 9; hz.rs_exe = 2;
    settle();
    lit1("id_fwd_a", hz.s_a_fwd_id, 1'b1);
    lit1("id_rt_imm_no_fwd", hz.s_b_fwd_id, 1'b0);
    nxt(); hz.use_rt_id = 1'b1;
    settle();
    lit1("id_fwd_b", hz.s_b_fwd_id, 1'b1);
    nxt(); hz.rs_exe = 9;
    settle();
    lit1("id_fwd_a_suppressed", hz.s_a_fwd_id, 1'b0);

    // Load-use: two bubbles, then WB forwarding when the consumer reaches EXE
    nxt(); load_use_r5();
    settle();
    litv("lu_bubble1", 32'({hz.nwrite_pc, hz.nwrite_if_id, hz.flush_id_exe}), 32'(3'b111));
    nxt(); idle(); hz.reg_write_mem = 1'b1; hz.num_write_mem = 5; hz.is_load_mem = 1'b1; hz.rs_id = 5;
    settle();
    litv("lu_bubble2", 32'({hz.nwrite_pc, hz.flush_id_exe}), 32'(2'b11));
    nxt(); idle(); hz.reg_write_wb = 1'b1; hz.num_write_wb = 5; hz.rs_exe = 5;
    settle();
    litv("lu_consumer_fwd_wb", 32'(hz.s_a_fwd_exe), 32'd2);
    lit1("lu_released", hz.nwrite_pc, 1'b0);
    litv("lu_stall_cycles", 32'(hz.stall_cycles), 32'd2);

    // Redirect overrides a simultaneous load-use hazard
    nxt(); load_use_r5(); hz.num_write_exe = 6; hz.rs_id = 6; hz.redirect_exe = 1'b1;
    settle();
    litv("redirect_flush", 32'({hz.flush_if_id, hz.flush_id_exe, hz.nwrite_pc}), 32'(3'b110));
    nxt(); idle();
    settle();
    lit1("redirect_stays_run", hz.nwrite_pc, 1'b0);

    // Memory freeze: 3 frozen cycles, timeout after the second, release on ready
    nxt(); idle(); hz.mem_req_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      litv("freeze_holds",
           32'({hz.nwrite_pc, hz.nwrite_if_id, hz.hold_exe_mem, hz.hold_mem_wb,
                hz.flush_if_id, hz.flush_id_exe}), 32'(6'b111100));
      lit1("freeze_timeout_rise", hz.mem_timeout, i == 2);
      nxt();
    end
    hz.mem_ready = 1'b1;
    settle();
    litv("ready_releases",
         32'({hz.nwrite_pc, hz.nwrite_if_id, hz.hold_exe_mem, hz.hold_mem_wb}), 32'd0);
    litv("freeze_stall_cycles", 32'(hz.stall_cycles), 32'd5);
    nxt(); idle();
    settle();
    lit1("timeout_sticky", hz.mem_timeout, 1'b1);

    // Reset in the middle of the bubble sequence
    nxt(); load_use_r5();
    nxt(); idle(); reset = 1'b1;
    settle();
    litv("rst_mid_lu_outputs", 32'({hz.flush_if_id, hz.flush_id_exe, hz.nwrite_pc}), 32'(3'b110));
    nxt(); reset = 1'b0;
    settle();
    lit1("after_rst_run", hz.nwrite_pc, 1'b0);
    litv("after_rst_stall_cycles", 32'(hz.stall_cycles), 32'd0);
    lit1("after_rst_timeout", hz.mem_timeout, 1'b0);

    // Stall counter saturation
    nxt(); hz.mem_req_mem = 1'b1;
    repeat (20) nxt();
    hz.mem_ready = 1'b1;
    settle();
    litv("stall_cycles_saturate", 32'(hz.stall_cycles), 32'(CNT_MAX));

    // Random phase against the model
    for (int i = 0; i < 3000; i++) begin
      nxt();
      reset            = ($urandom_range(0, 59) == 0);
      hz.rs_id         = REG_AW'($urandom_range(0, 7));
      hz.rt_id         = REG_AW'($urandom_range(0, 7));
      hz.use_rt_id     = ($urandom_range(0, 1) == 0);
      hz.rs_exe        = REG_AW'($urandom_range(0, 7));
      hz.rt_exe        = REG_AW'($urandom_range(0, 7));
      hz.num_write_exe = REG_AW'($urandom_range(0, 7));
      hz.num_write_mem = REG_AW'($urandom_range(0, 7));
      hz.num_write_wb  = REG_AW'($urandom_range(0, 7));
      hz.reg_write_exe = ($urandom_range(0, 3) != 0);
      hz.reg_write_mem = ($urandom_range(0, 3) != 0);
      hz.reg_write_wb  = ($urandom_range(0, 3) != 0);
      hz.is_load_exe   = ($urandom_range(0, 4) < 2);
      hz.is_load_mem   = ($urandom_range(0, 4) < 2);
      hz.redirect_exe  = ($urandom_range(0, 7) == 0);
      hz.mem_req_mem   = ($urandom_range(0, 2) == 0);
      hz.mem_ready     = ($urandom_range(0, 1) == 0);
    end
    nxt();
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Centralised hazard and forwarding controller for the 5-stage MIPS pipeline CPU (IF/ID/EXE/MEM/WB). It generates the forwarding mux selects for the EXE operands (MEM→EXE, WB→EXE) and the ID operands (WB→ID). It also drives stall, hold and flush controls for load-use hazards, taken-branch/jump redirects resolved in EXE, and a variable-latency data memory with a req/ready handshake. It replaces the ad-hoc forwarding/halt logic in the top level and adds configurable load-use bubble depth, redirect flushing, memory-wait freeze, timeout detection and a stall performance counter.

Parameters:
REG_AW, 5, register-number width
LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..7)
MAX_WAIT, 255, freeze cycles before mem_timeout is raised (1..2^WAIT_W-1)
WAIT_W, 8, width of the memory-wait counter
CNT_W, 32, width of the stall performance counter

Ports:
clock  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
rs_id, rt_id  in  REG_AW  source registers of the instruction in ID
use_rt_id  in  1  ID instruction reads rt as a register (0 when rt is an immediate destination)
rs_exe, rt_exe  in  REG_AW  source registers in EXE
num_write_exe, num_write_mem, num_write_wb  in  REG_AW  destination registers per stage
reg_write_exe, reg_write_mem, reg_write_wb  in  1  stage writes the GPR
is_load_exe, is_load_mem  in  1  stage holds a load
redirect_exe  in  1  taken branch/jump resolved in EXE
mem_req_mem  in  1  MEM stage is accessing DM
mem_ready  in  1  DM completes the access this cycle
s_a_fwd_exe, s_b_fwd_exe  out  2  0 = none, 1 = MEM, 2 = WB
s_a_fwd_id, s_b_fwd_id  out  1  0 = GPR, 1 = WB data
nwrite_pc, nwrite_if_id  out  1  hold PC / IF-ID register
flush_if_id, flush_id_exe  out  1  load NOP/bubble into the register
hold_exe_mem, hold_mem_wb  out  1  hold the later stage registers
mem_timeout  out  1  sticky: freeze exceeded MAX_WAIT
stall_cycles  out  CNT_W  saturating count of cycles with nwrite_pc = 1

Behaviour:
- Match rule: a producer qualifies only if reg_write = 1 and num_write ≠ 0.
- EXE forwarding (per operand):
  - Select MEM when the MEM producer qualifies, matches the operand and is_load_mem = 0.
  - Otherwise select WB when the WB producer qualifies and matches.
  - Otherwise select none.
  - MEM has priority over WB. Forwarding selects are combinational and are valid during stalls.
- ID forwarding: select WB when the WB producer qualifies and matches rs_id (or rt_id with use_rt_id = 1), and no EXE-stage select for the same operand register number is non-zero.
- freeze = mem_req_mem & ~mem_ready. While freeze = 1, the PC and all stage registers hold and no flushes are issued.
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset state is RUN.
- RUN:
  - If freeze, go to MEM_WAIT.
  - Else if redirect_exe: flush_if_id = 1 and flush_id_exe = 1 for that cycle; PC loads the target (nwrite_pc = 0). Redirect overrides a load-use hazard in the same cycle.
  - Else if load-use hazard: nwrite_pc = 1, nwrite_if_id = 1, flush_id_exe = 1. If LU_BUBBLES > 1, go to LU_STALL with bcnt = LU_BUBBLES−1.
  - Load-use hazard = is_load_exe & reg_write_exe & num_write_exe ≠ 0 & (num_write_exe == rs_id | (use_rt_id & num_write_exe == rt_id)).
- LU_STALL:
  - Stall outputs as for a load-use hazard; bcnt decrements each cycle.
  - Exit to RUN when bcnt reaches 0.
  - Freeze pre-empts: go to MEM_WAIT with bcnt preserved, then return to LU_STALL if bcnt ≠ 0.
- MEM_WAIT:
  - All holds asserted; wcnt increments (saturating).
  - When wcnt == MAX_WAIT, set mem_timeout (cleared only by reset); the pipeline stays frozen.
  - On mem_ready = 1, release that same cycle: wcnt = 0 and return to the resumed state.
  - A redirect pending in EXE is applied in the first non-frozen cycle.
- Output priority: freeze > redirect > load-use.
- stall_cycles increments when nwrite_pc = 1 and saturates at all-ones.
- Reset (synchronous, active-high): state = RUN, bcnt = 0, wcnt = 0, mem_timeout = 0, stall_cycles = 0. All hold/flush outputs are 0 during the reset cycle except flush_if_id = flush_id_exe = 1.

Decomposition:
- Shared package hazard_pkg:
  - Forwarding encodings FWD_NONE = 0, FWD_MEM = 1, FWD_WB = 2; ID_NOFWD = 0, WB2ID_FWD = 1.
  - FSM state encodings.
  - INSTRUCTION_NOP.
- One natural sub-module, fwd_select: combinational per-operand priority selector, instantiated four times (two EXE operands, two ID operands).

Test Plan:
- Dependent ALU pair (add r3 then sub r4,r3,r1), reg_write_mem = 1, num_write_mem = 3, rs_exe = 3 → s_a_fwd_exe = 1, no stall.
- Load-use with LU_BUBBLES = 2: lw r5 in EXE, rs_id = 5 → nwrite_pc = 1 for 2 cycles, flush_id_exe = 1 on both, then s_a_fwd_exe = 2 when the consumer reaches EXE; stall_cycles = 2.
- num_write_mem = 0, reg_write_mem = 1, rs_exe = 0 → s_a_fwd_exe = 0; num_write_mem = 7, reg_write_mem = 0, rs_exe = 7 → no forwarding.
- redirect_exe = 1 coinciding with a load-use hazard → flush_if_id = 1, flush_id_exe = 1, nwrite_pc = 0, state stays RUN.
- mem_req_mem = 1, mem_ready low for 3 cycles → all holds = 1 for exactly 3 cycles, release on the ready cycle; with MAX_WAIT = 2, mem_timeout rises after the second frozen cycle and stays high until reset.
- reset asserted mid LU_STALL → next cycle state = RUN, stall_cycles = 0, mem_timeout = 0.
